gray_frame_writer: RTL and testbench
====================================

// Module: gray_frame_writer
// PURPOSE
//  Captures one gray frame from a streaming video source (vs/de/pixel) into the 240x130 gray RAM.
//  Drives that RAM's write port (wr_req/gray_data_in/gray_data_addra), then raises enable to start
//  the downstream 32x32 window-cut/convolution stage.
//  Holds the frame (no writes) until the downstream stage returns proc_done, then re-arms on start.
// PARAMETERS
//  IMG_W   240  stored image width, pixels
//  IMG_H   130  stored image height, lines
//  X_OFF   0    first source column captured, crop offset
//  Y_OFF   0    first source line captured, crop offset
//  ADDR_W  15   gray RAM address width; IMG_W*IMG_H <= 2**ADDR_W
//  CNT_W   11   source column/line counter width
// PORTS
//  clk              in   1       clock
//  rst_n            in   1       reset, asynchronous, active-low
//  start            in   1       arm capture of next frame; sampled only in IDLE
//  vs               in   1       source vertical sync, active-high; rising edge = frame start
//  de               in   1       source data enable; one pixel per cycle while high
//  pix_in           in   8       source gray pixel, valid when de=1
//  proc_done        in   1       1-cycle pulse from downstream: frame consumed
//  wr_req           out  1       gray RAM write strobe
//  gray_data_in     out  8       gray RAM write data
//  gray_data_addra  out  ADDR_W  gray RAM write address
//  enable           out  1       frame valid in RAM; downstream processing enabled
//  busy             out  1       state != IDLE
//  frame_err        out  1       1-cycle pulse: capture aborted (early vs or short line)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, all counters 0. Reset mid-capture discards the partial frame.
//  vs edge: vs_d registered; vs_rise = vs & ~vs_d. de_fall = ~de & de_d.
//  FSM
//   IDLE    : start=1 -> ARM. Otherwise stay.
//   ARM     : vs_rise -> CAPTURE; clear x, y, and wcnt.
//   CAPTURE : per de=1 cycle, x++ (saturates at 2**CNT_W-1). On de_fall: y++ (saturating), x=0.
//             Pixel is in window iff X_OFF<=x<X_OFF+IMG_W and Y_OFF<=y<Y_OFF+IMG_H.
//             In-window pixel -> registered write next cycle: wr_req=1, gray_data_in=pix_in,
//             gray_data_addra=wcnt, then wcnt++.
//             wcnt is a running counter; no multiplier. Row-major order, address = row*IMG_W+col.
//             Write with wcnt==IMG_W*IMG_H-1 (31199 default) -> HANDOFF on the following cycle.
//             vs_rise before completion: frame_err pulse; clear x, y, and wcnt; stay CAPTURE (restart).
//             de_fall on in-window line with x < X_OFF+IMG_W (short line): frame_err pulse -> ARM.
//   HANDOFF : enable=1 (asserted 1 cycle after the last wr_req). wr_req held 0. Source input ignored.
//             proc_done=1 -> IDLE; enable=0 on the next cycle.
//  Latency: pix_in to write port = 1 cycle. At most one write per cycle.
//  Invariant: wr_req & enable never both 1. wr_req only in CAPTURE.
//  gray_data_addra holds its last value when wr_req=0. Exactly IMG_W*IMG_H writes per good frame.
//  start outside IDLE and proc_done outside HANDOFF are ignored.
//  Pixels beyond the window, extra lines, and vs edges in ARM-after-match or HANDOFF are ignored.
// TESTING
//  1 Defaults, 240x130 source, start then one frame -> 31200 wr_req, addr 0..31199 matches pix order;
//    enable=1 exactly 1 cycle after the last write.
//  2 X_OFF=8, Y_OFF=2, 256x140 source with pix=(x+y)&255 -> addr 0 data 10; addr 239 data 249;
//    31200 writes total.
//  3 vs_rise after 1000 writes -> frame_err 1 cycle; next write has addr 0; full frame completes.
//  4 In-window line of 100 px -> frame_err; state ARM; enable stays 0; next good frame captures OK.
//  5 In HANDOFF: feed frames and a 2nd start -> no wr_req. proc_done -> enable=0 next cycle, busy=0.
//  6 rst_n low mid-CAPTURE -> all outputs 0 immediately; after release, start + frame captures from addr 0.

Source files
------------

// File: rtl/gray_frame_writer.sv
// Captures one cropped gray frame from a vs/de/pixel stream into the gray RAM write port,
// then hands the frame to the downstream window stage and holds it until proc_done.
module gray_frame_writer #(
    parameter int IMG_W  = 240,
    parameter int IMG_H  = 130,
    parameter int X_OFF  = 0,
    parameter int Y_OFF  = 0,
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              vs,
    input  logic              de,
    input  logic [7:0]        pix_in,
    input  logic              proc_done,
    output logic              wr_req,
    output logic [7:0]        gray_data_in,
    output logic [ADDR_W-1:0] gray_data_addra,
    output logic              enable,
    output logic              busy,
    output logic              frame_err
);

    localparam logic [CNT_W-1:0]  X_LO      = CNT_W'(X_OFF);
    localparam logic [CNT_W-1:0]  Y_LO      = CNT_W'(Y_OFF);
    localparam logic [CNT_W-1:0]  X_SPAN    = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0]  Y_SPAN    = CNT_W'(IMG_H);
    localparam logic [CNT_W-1:0]  X_HI      = CNT_W'(X_OFF + IMG_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_HANDOFF} state_t;

    state_t             r_state, w_next;
    logic               r_vs_d, r_de_d;
    logic [CNT_W-1:0]   r_x, r_y;
    logic [ADDR_W-1:0]  r_wcnt;
    logic               r_wr_req, r_err;
    logic [7:0]         r_data;
    logic [ADDR_W-1:0]  r_addr;

    logic w_vs_rise, w_de_fall, w_x_in, w_y_in, w_last_wr;
    logic w_clear, w_count, w_accept, w_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign w_vs_rise = vs & ~r_vs_d;
    assign w_de_fall = ~de & r_de_d;
    // Offset subtraction wraps below the window start, so one compare covers both bounds.
    assign w_x_in    = (r_x - X_LO) < X_SPAN;
    assign w_y_in    = (r_y - Y_LO) < Y_SPAN;
    assign w_last_wr = r_wr_req && (r_addr == LAST_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_clear  = 1'b0;
        w_count  = 1'b0;
        w_accept = 1'b0;
        w_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_ARM;
            end
            S_ARM: begin
                if (w_vs_rise) begin
                    w_next  = S_CAPTURE;
                    w_clear = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (w_last_wr) begin
                    w_next = S_HANDOFF;
                end else if (w_vs_rise) begin
                    w_err   = 1'b1;
                    w_clear = 1'b1;
                end else if (w_de_fall && w_y_in && (r_x < X_HI)) begin
                    w_err  = 1'b1;
                    w_next = S_ARM;
                end else begin
                    w_count  = 1'b1;
                    w_accept = de & w_x_in & w_y_in;
                end
            end
            S_HANDOFF: begin
                if (proc_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d <= 1'b0;
            r_de_d <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
            r_wcnt <= '0;
        end else begin
            r_vs_d <= vs;
            r_de_d <= de;
            if (w_clear) begin
                r_x    <= '0;
                r_y    <= '0;
                r_wcnt <= '0;
            end else if (w_count) begin
                if (de) begin
                    r_x <= sat_inc(r_x);
                end else if (w_de_fall) begin
                    r_x <= '0;
                    r_y <= sat_inc(r_y);
                end
                if (w_accept) r_wcnt <= r_wcnt + 1'b1;
            end
        end
    end

    // Write port is registered: the pixel accepted this cycle is written on the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_req <= 1'b0;
            r_data   <= '0;
            r_addr   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_wr_req <= w_accept;
            r_err    <= w_err;
            if (w_accept) begin
                r_data <= pix_in;
                r_addr <= r_wcnt;
            end
        end
    end

    assign wr_req          = r_wr_req;
    assign gray_data_in    = r_data;
    assign gray_data_addra = r_addr;
    assign frame_err       = r_err;
    assign enable          = (r_state == S_HANDOFF);
    assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_gray_frame_writer.sv
// Bench for gray_frame_writer: a full-size default instance and a cropped short-frame instance
// share one randomized video source; writes are checked against a row-major crop model.
module tb_gray_frame_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs, de;
    logic [7:0]  pix;
    logic        start_a, start_b, pd_a, pd_b;

    logic        wr_a, en_a, busy_a, ferr_a;
    logic [7:0]  data_a;
    logic [14:0] addr_a;
    logic        wr_b, en_b, busy_b, ferr_b;
    logic [7:0]  data_b;
    logic [14:0] addr_b;

    gray_frame_writer dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .vs(vs), .de(de), .pix_in(pix),
        .proc_done(pd_a), .wr_req(wr_a), .gray_data_in(data_a), .gray_data_addra(addr_a),
        .enable(en_a), .busy(busy_a), .frame_err(ferr_a)
    );

    gray_frame_writer #(
        .IMG_W(240), .IMG_H(4), .X_OFF(8), .Y_OFF(2), .ADDR_W(15), .CNT_W(11)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .vs(vs), .de(de), .pix_in(pix),
        .proc_done(pd_b), .wr_req(wr_b), .gray_data_in(data_b), .gray_data_addra(addr_b),
        .enable(en_b), .busy(busy_b), .frame_err(ferr_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    int src [0:65535];

    int wa_addr [0:65535];
    int wa_data [0:65535];
    int wa_n = 0, a_last_wr = 0, a_en_rise = 0, a_overlap = 0;
    bit a_en_prev = 1'b0;
    int wb_addr [0:65535];
    int wb_data [0:65535];
    int wb_n = 0, b_last_wr = 0, b_en_rise = 0, b_overlap = 0, b_ferr_n = 0, b_ferr_long = 0;
    bit b_en_prev = 1'b0, b_ferr_prev = 1'b0;

    always @(negedge clk) begin
        if (wr_a && wa_n < 65536) begin
            wa_addr[wa_n] = int'(addr_a);
            wa_data[wa_n] = int'(data_a);
            wa_n = wa_n + 1;
            a_last_wr = cyc;
        end
        if (en_a && !a_en_prev) a_en_rise = cyc;
        a_en_prev = en_a;
        if (wr_a && en_a) a_overlap = a_overlap + 1;
    end

    always @(negedge clk) begin
        if (wr_b && wb_n < 65536) begin
            wb_addr[wb_n] = int'(addr_b);
            wb_data[wb_n] = int'(data_b);
            wb_n = wb_n + 1;
            b_last_wr = cyc;
        end
        if (en_b && !b_en_prev) b_en_rise = cyc;
        b_en_prev = en_b;
        if (wr_b && en_b) b_overlap = b_overlap + 1;
        if (ferr_b) begin
            b_ferr_n = b_ferr_n + 1;
            if (b_ferr_prev) b_ferr_long = b_ferr_long + 1;
        end
        b_ferr_prev = ferr_b;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk = n_chk + 1;
        if (obs == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One source frame: vs pulse, then h lines of w pixels (line short_y is short_len long).
    task automatic send_frame(input int w, input int h, input bit pat, input int short_y,
                              input int short_len);
        int len;
        vs = 1'b1; tick(); tick();
        vs = 1'b0; tick(); tick();
        for (int y = 0; y < h; y++) begin
            len = (y == short_y) ? short_len : w;
            for (int x = 0; x < len; x++) begin
                de  = 1'b1;
                pix = pat ? 8'(x + y) : 8'($urandom);
                src[y * w + x] = int'(pix);
                tick();
            end
            de  = 1'b0;
            pix = 8'h00;
            repeat (4) tick();
        end
        repeat (4) tick();
    endtask

    // Reference: the i-th write of a good frame is crop pixel (i / img_w, i % img_w) at address i.
    task automatic verify(input string tag, input bit sel, input int base, input int n_exp,
                          input int img_w, input int xo, input int yo, input int srcw);
        int n, bad, a, d, e;
        n   = (sel ? wb_n : wa_n) - base;
        chk({tag, "_count"}, n, n_exp);
        bad = -1;
        for (int i = 0; i < n && bad < 0; i++) begin
            a = sel ? wb_addr[base + i] : wa_addr[base + i];
            d = sel ? wb_data[base + i] : wa_data[base + i];
            e = src[(i / img_w + yo) * srcw + (i % img_w) + xo];
            if (a != i || d != e) bad = i;
        end
        chk({tag, "_first_bad_write"}, bad, -1);
    endtask

    task automatic pulse_start_b();
        start_b = 1'b1; tick(); start_b = 1'b0;
    endtask

    task automatic pulse_done_b();
        pd_b = 1'b1; tick(); pd_b = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, f0;
        rst_n = 1'b0; vs = 1'b0; de = 1'b0; pix = 8'h00;
        start_a = 1'b0; start_b = 1'b0; pd_a = 1'b0; pd_b = 1'b0;
        repeat (3) tick();
        chk("rst_outs_a", {wr_a, en_a, busy_a, ferr_a, data_a, addr_a}, 0);
        chk("rst_outs_b", {wr_b, en_b, busy_b, ferr_b, data_b, addr_b}, 0);
        rst_n = 1'b1;
        tick();

        // Full-size frame, default crop.
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("t1_busy", busy_a, 1);
        send_frame(240, 130, 1'b0, -1, 0);
        verify("t1", 1'b0, 0, 31200, 240, 0, 0, 240);
        chk("t1_enable_latency", a_en_rise - a_last_wr, 1);
        chk("t1_enable", en_a, 1);
        pd_a = 1'b1; tick(); pd_a = 1'b0;
        chk("t1_released", {en_a, busy_a}, 0);

        // Offset crop with a diagonal-ramp pattern.
        pulse_start_b();
        base = wb_n;
        send_frame(256, 8, 1'b1, -1, 0);
        verify("t2", 1'b1, base, 960, 240, 8, 2, 256);
        chk("t2_addr0_data", wb_data[base], 10);
        chk("t2_addr239_data", wb_data[base + 239], 249);
        chk("t2_addr240_data", wb_data[base + 240], 11);
        chk("t2_enable_latency", b_en_rise - b_last_wr, 1);
        pulse_done_b();

        // Early vs restarts the capture.
        pulse_start_b();
        base = wb_n;
        f0 = b_ferr_n;
        send_frame(256, 4, 1'b0, -1, 0);
        chk("t3_partial_writes", wb_n - base, 480);
        chk("t3_partial_no_err", b_ferr_n - f0, 0);
        base = wb_n;
        send_frame(256, 8, 1'b0, -1, 0);
        chk("t3_frame_err_pulses", b_ferr_n - f0, 1);
        chk("t3_frame_err_long", b_ferr_long, 0);
        verify("t3", 1'b1, base, 960, 240, 8, 2, 256);
        chk("t3_enable", en_b, 1);

        // Held frame ignores new video and a second start.
        base = wb_n;
        pulse_start_b();
        send_frame(256, 8, 1'b0, -1, 0);
        chk("t5_no_writes", wb_n - base, 0);
        chk("t5_enable_held", en_b, 1);
        pulse_done_b();
        chk("t5_enable_off", en_b, 0);
        chk("t5_busy_off", busy_b, 0);

        // Short in-window line aborts back to ARM.
        pulse_start_b();
        base = wb_n;
        f0 = b_ferr_n;
        send_frame(256, 8, 1'b0, 3, 100);
        chk("t4_writes_before_abort", wb_n - base, 332);
        chk("t4_frame_err_pulses", b_ferr_n - f0, 1);
        chk("t4_busy_enable", {busy_b, en_b}, 2'b10);
        base = wb_n;
        send_frame(256, 8, 1'b0, -1, 0);
        verify("t4", 1'b1, base, 960, 240, 8, 2, 256);
        chk("t4_enable", en_b, 1);
        pulse_done_b();

        // Asynchronous reset in the middle of a capture line.
        pulse_start_b();
        base = wb_n;
        fork
            send_frame(256, 8, 1'b0, -1, 0);
            begin
                for (int k = 0; k < 5000 && (wb_n - base) < 300; k++) tick();
                chk("t6_reached_midframe", (wb_n - base) >= 300, 1);
                #2;
                rst_n = 1'b0;
                #1;
                chk("t6_wr_req", wr_b, 0);
                chk("t6_addr", addr_b, 0);
                chk("t6_other_outs", {data_b, en_b, busy_b, ferr_b}, 0);
                repeat (2) tick();
                #2;
                rst_n = 1'b1;
            end
        join
        chk("t6_idle_after_reset", busy_b, 0);
        pulse_start_b();
        base = wb_n;
        send_frame(256, 8, 1'b0, -1, 0);
        verify("t6", 1'b1, base, 960, 240, 8, 2, 256);
        pulse_done_b();

        chk("overlap_a", a_overlap, 0);
        chk("overlap_b", b_overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
